memory_scheduler: RTL and testbench
===================================

Name: memory_scheduler

Overview:
Sequencer and two-requester arbiter for the three-bank on-chip memory (bank0 2048 words, bank1 1024, bank2 512; 16-bit words; one flat 13-bit address space).
- Contains a fill engine that writes a pattern to every mapped word.
- Outside fill, requester A and requester B share the banks by round-robin; one access per cycle.
- Decodes flat addresses to bank enable and bank-local address, and returns read data one cycle later.

Parameters:
ADDR_W, 13, flat address width
DATA_W, 16, word width
B0_DEPTH, 2048, bank0 words (flat base 0)
B1_DEPTH, 1024, bank1 words (flat base B0_DEPTH)
B2_DEPTH, 512, bank2 words (flat base B0_DEPTH+B1_DEPTH)

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low (0 = reset)
fill_start  in  1  one-cycle pulse, starts fill
fill_pattern  in  DATA_W  value written by fill, sampled at fill_start
fill_busy  out  1  fill in progress
fill_done  out  1  one-cycle pulse after last fill write
a_req, b_req  in  1  access request, held until granted
a_we, b_we  in  1  1 = write, 0 = read
a_addr, b_addr  in  ADDR_W  flat address
a_wdata, b_wdata  in  DATA_W  write data
a_gnt, b_gnt  out  1  combinational grant; the access executes in this cycle
a_rvalid, b_rvalid  out  1  read data valid, one cycle after a granted read
a_rdata, b_rdata  out  DATA_W  read data, 0 when rvalid is low
a_err, b_err  out  1  pulse one cycle after a granted out-of-range access
bank_addr  out  11  bank-local address (read and write)
bank_d  out  DATA_W  write data to all banks
bank_we  out  3  one-hot write enable, bit i = bank i
q0, q1, q2  in  DATA_W  bank read data, registered by the bank, valid one clock after bank_addr

Behaviour:
- Reset (reset=0 at a clock edge): FSM goes to IDLE, round-robin pointer favours A, fill counter is 0.
  - All registered outputs are 0.
  - gnt and bank_we are forced 0 while reset is low.
  - A fill in progress is aborted; no fill_done pulse.
- FSM states:
  - IDLE: fill_start moves to FILL; counter is 0 and the pattern is latched.
  - FILL: write pattern at the counter address each cycle and increment. After the write at address 3583, move to DONE.
  - DONE: fill_done=1 for one cycle, then IDLE.
- fill_busy=1 in FILL and DONE.
- fill_start is ignored outside IDLE.
- No requester grants in FILL or DONE. Requests stay pending.
- A full fill takes 3584 write cycles; fill_done is high in cycle 3585 after the start edge.
- Address decode (flat address f):
  - f < 2048: bank0, local = f[10:0].
  - f < 3072: bank1, local = f-2048.
  - f < 3584: bank2, local = f-3072.
  - f >= 3584: unmapped. bank_we=0; one cycle later rvalid=1 (reads only), rdata=0, err=1.
- Arbitration in IDLE:
  - One requester asserting: it is granted.
  - Both asserting: grant the one not granted most recently.
  - The pointer updates only on a grant.
- fill_start and a request in the same IDLE cycle: the request is granted that cycle, then fill begins next cycle.
- Granted write: bank_we one-hot, bank_d = wdata. Write commits on that edge.
- Granted read: bank_we=0.
  - Bank select and requester id are registered.
  - Next cycle, rvalid of that requester=1, rdata = selected q.
  - Back-to-back reads from alternating requesters stream at one per cycle.
- No read/write forwarding. A read in the cycle after a write to the same address returns what the bank returns.
- Idle cycles: bank_addr and bank_d hold their last values, bank_we=0.

Decomposition:
- Package memory_map_pkg:
  - Bank base and depth constants, total mapped words (3584).
  - FSM state enum {IDLE, FILL, DONE}.
  - Requester id typedef.
- One sub-module, memory_bank_decode: combinational flat address to {bank one-hot, local address, unmapped flag}. Shared by the fill path and the requester path.

Test Plan:
- Reset low mid-fill at counter 100 -> next cycle fill_busy=0, bank_we=0; fill_done never pulses.
- fill_start with pattern 16'hFFFF -> 3584 writes: bank0 addr 0..2047, bank1 0..1023, bank2 0..511. fill_done pulses once; a_req held throughout gets a_gnt only after DONE.
- A writes 16'h1234 to 2050, then reads 2050 -> bank_we=3'b010 and bank_addr=2 on the write; a_rvalid one cycle after the read grant with a_rdata=q1.
- a_req and b_req held high for 6 cycles after reset -> grants alternate A,B,A,B,A,B. Each read's rvalid lands on the matching requester.
- b reads address 3584 (and 8191) -> bank_we=0, b_rvalid=1, b_rdata=0, b_err=1 one cycle later. A write to 3584 gives b_err=1, b_rvalid=0.
- Boundary addresses 2047, 2048, 3071, 3072, 3583 -> banks 0,1,1,2,2 with locals 2047, 0, 1023, 0, 511.

Source files
------------

// File: rtl/memory_map_pkg.sv
// Memory map and shared types for the three-bank on-chip memory scheduler.
// Bank0 sits at flat base 0, bank1 follows it, bank2 follows bank1; any
// flat address at or above TOTAL_WORDS is unmapped.
package memory_map_pkg;

    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 16;
    localparam int LOCAL_W     = 11;
    localparam int NUM_BANKS   = 3;

    localparam int B0_DEPTH    = 2048;
    localparam int B1_DEPTH    = 1024;
    localparam int B2_DEPTH    = 512;

    localparam int B0_BASE     = 0;
    localparam int B1_BASE     = B0_BASE + B0_DEPTH;
    localparam int B2_BASE     = B1_BASE + B1_DEPTH;
    localparam int TOTAL_WORDS = B2_BASE + B2_DEPTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/memory_bank_decode.sv
// Flat address to bank decode, shared by the fill engine and the requester
// path.
//   i_addr      flat address
//   o_bank_oh   one-hot bank select (bit i = bank i), 0 when unmapped
//   o_local     bank-local word address
//   o_unmapped  flat address lies beyond the last mapped word
module memory_bank_decode
    import memory_map_pkg::*;
(
    input  logic [ADDR_W-1:0]    i_addr,
    output logic [NUM_BANKS-1:0] o_bank_oh,
    output logic [LOCAL_W-1:0]   o_local,
    output logic                 o_unmapped
);

    always_comb begin
        o_bank_oh  = '0;
        o_local    = i_addr[LOCAL_W-1:0];
        o_unmapped = 1'b0;
        if (i_addr < ADDR_W'(B1_BASE)) begin
            o_bank_oh = 3'b001;
        end else if (i_addr < ADDR_W'(B2_BASE)) begin
            o_bank_oh = 3'b010;
            o_local   = LOCAL_W'(i_addr - ADDR_W'(B1_BASE));
        end else if (i_addr < ADDR_W'(TOTAL_WORDS)) begin
            o_bank_oh = 3'b100;
            o_local   = LOCAL_W'(i_addr - ADDR_W'(B2_BASE));
        end else begin
            o_unmapped = 1'b1;
        end
    end

endmodule

// File: rtl/memory_scheduler.sv
// Fill sequencer plus two-requester round-robin arbiter for the three-bank
// memory. One bank access per cycle; read data returns one cycle after the
// grant, muxed from the bank registered outputs.
//
//   state | meaning
//   IDLE  | requesters arbitrated; fill_start latches pattern and clears counter
//   FILL  | one pattern write per cycle at the counter address
//   DONE  | fill_done pulse, back to IDLE
//
// Ports: clk/reset (sync, active-low); fill_start/fill_pattern/fill_busy/
// fill_done fill control; a_*/b_* requester interfaces (req, we, addr,
// wdata, gnt, rvalid, rdata, err); bank_addr/bank_d/bank_we drive the banks;
// q0..q2 are the bank read data.
module memory_scheduler
    import memory_map_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fill_start,
    input  logic [DATA_W-1:0]    fill_pattern,
    output logic                 fill_busy,
    output logic                 fill_done,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [DATA_W-1:0]    a_rdata,
    output logic                 a_err,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [DATA_W-1:0]    b_rdata,
    output logic                 b_err,
    output logic [LOCAL_W-1:0]   bank_addr,
    output logic [DATA_W-1:0]    bank_d,
    output logic [NUM_BANKS-1:0] bank_we,
    input  logic [DATA_W-1:0]    q0,
    input  logic [DATA_W-1:0]    q1,
    input  logic [DATA_W-1:0]    q2
);

    fill_state_t            r_state;
    fill_state_t            w_state_nxt;
    logic [ADDR_W-1:0]      r_cnt;
    logic [DATA_W-1:0]      r_pattern;
    req_id_t                r_last;
    logic [LOCAL_W-1:0]     r_bank_addr;
    logic [DATA_W-1:0]      r_bank_d;
    logic                   r_rd_valid;
    logic                   r_err;
    req_id_t                r_rd_id;
    logic [NUM_BANKS-1:0]   r_rd_bank;

    logic                   w_gnt_a;
    logic                   w_gnt_b;
    logic                   w_fill_act;
    logic                   w_access;
    logic                   w_we;
    logic [ADDR_W-1:0]      w_dec_addr;
    logic [DATA_W-1:0]      w_wdata;
    logic [NUM_BANKS-1:0]   w_dec_oh;
    logic [LOCAL_W-1:0]     w_dec_local;
    logic                   w_dec_unmapped;
    logic [DATA_W-1:0]      w_rdata;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        case (r_state)
            IDLE: begin
                // On contention the requester that did not win last time goes.
                w_gnt_a = a_req && (!b_req || r_last == REQ_B);
                w_gnt_b = b_req && (!a_req || r_last == REQ_A);
                if (fill_start) w_state_nxt = FILL;
            end
            FILL: begin
                if (r_cnt == ADDR_W'(TOTAL_WORDS - 1)) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (!reset) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end
    end

    assign w_fill_act = (r_state == FILL) && reset;
    assign w_access   = w_fill_act || w_gnt_a || w_gnt_b;
    assign w_we       = w_fill_act || (w_gnt_a && a_we) || (w_gnt_b && b_we);
    assign w_dec_addr = (r_state == FILL) ? r_cnt : (w_gnt_b ? b_addr : a_addr);
    assign w_wdata    = (r_state == FILL) ? r_pattern : (w_gnt_b ? b_wdata : a_wdata);

    memory_bank_decode u_decode (
        .i_addr     (w_dec_addr),
        .o_bank_oh  (w_dec_oh),
        .o_local    (w_dec_local),
        .o_unmapped (w_dec_unmapped)
    );

    // Unmapped addresses decode to an all-zero one-hot, so no bank is written.
    assign bank_we   = w_we ? w_dec_oh : '0;
    assign bank_addr = w_access ? w_dec_local : r_bank_addr;
    assign bank_d    = w_we ? w_wdata : r_bank_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_pattern   <= '0;
            r_last      <= REQ_B;
            r_bank_addr <= '0;
            r_bank_d    <= '0;
            r_rd_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_rd_id     <= REQ_A;
            r_rd_bank   <= '0;
        end else begin
            if (r_state == IDLE && fill_start) begin
                r_cnt     <= '0;
                r_pattern <= fill_pattern;
            end else if (r_state == FILL) begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end
            if (w_gnt_a)      r_last <= REQ_A;
            else if (w_gnt_b) r_last <= REQ_B;
            if (w_access) r_bank_addr <= w_dec_local;
            if (w_we)     r_bank_d    <= w_wdata;
            r_rd_valid <= (w_gnt_a && !a_we) || (w_gnt_b && !b_we);
            r_err      <= (w_gnt_a || w_gnt_b) && w_dec_unmapped;
            r_rd_id    <= w_gnt_b ? REQ_B : REQ_A;
            r_rd_bank  <= w_dec_oh;
        end
    end

    assign w_rdata = ({DATA_W{r_rd_bank[0]}} & q0)
                   | ({DATA_W{r_rd_bank[1]}} & q1)
                   | ({DATA_W{r_rd_bank[2]}} & q2);

    assign a_gnt     = w_gnt_a;
    assign b_gnt     = w_gnt_b;
    assign a_rvalid  = r_rd_valid && (r_rd_id == REQ_A);
    assign b_rvalid  = r_rd_valid && (r_rd_id == REQ_B);
    assign a_err     = r_err && (r_rd_id == REQ_A);
    assign b_err     = r_err && (r_rd_id == REQ_B);
    assign a_rdata   = a_rvalid ? w_rdata : '0;
    assign b_rdata   = b_rvalid ? w_rdata : '0;
    assign fill_busy = (r_state != IDLE);
    assign fill_done = (r_state == DONE);

endmodule

// File: tb/tb_memory_scheduler.sv
module tb_memory_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        fill_start;
    logic [15:0] fill_pattern;
    logic        fill_busy, fill_done;
    logic        a_req, a_we, a_gnt, a_rvalid, a_err;
    logic [12:0] a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid, b_err;
    logic [12:0] b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [10:0] bank_addr;
    logic [15:0] bank_d;
    logic [2:0]  bank_we;
    logic [15:0] q0, q1, q2;

    always #5 clk = ~clk;

    memory_scheduler dut (
        .clk(clk), .reset(reset),
        .fill_start(fill_start), .fill_pattern(fill_pattern),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .bank_addr(bank_addr), .bank_d(bank_d), .bank_we(bank_we),
        .q0(q0), .q1(q1), .q2(q2)
    );

    // Bank models: synchronous read (old data on a same-edge write), write on we.
    logic [15:0] mem0 [2048];
    logic [15:0] mem1 [1024];
    logic [15:0] mem2 [512];
    always @(posedge clk) begin
        q0 <= mem0[bank_addr];
        q1 <= mem1[bank_addr[9:0]];
        q2 <= mem2[bank_addr[8:0]];
        if (bank_we[0]) mem0[bank_addr]      <= bank_d;
        if (bank_we[1]) mem1[bank_addr[9:0]] <= bank_d;
        if (bank_we[2]) mem2[bank_addr[8:0]] <= bank_d;
    end

    // Reference model: flat word array, who won last, next-cycle expectations.
    logic [15:0] ref_mem [3584];
    logic        last_b;
    logic        pa_rv, pa_err, pb_rv, pb_err;
    logic [15:0] pa_rd, pb_rd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_oh(input int f);
        if (f < 2048) return 3'b001;
        if (f < 3072) return 3'b010;
        if (f < 3584) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [10:0] exp_local(input int f);
        if (f < 2048) return 11'(f);
        if (f < 3072) return 11'(f - 2048);
        return 11'(f - 3072);
    endfunction

    task automatic clear_model();
        last_b = 1'b1;
        pa_rv = 0; pa_err = 0; pa_rd = '0;
        pb_rv = 0; pb_err = 0; pb_rd = '0;
    endtask

    // One IDLE-state cycle: drive requests at posedge+1, check at posedge+2,
    // then advance to the next posedge+1. Returns what the DUT did.
    task automatic cyc(input logic ar, input logic aw, input logic [12:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [12:0] ba, input logic [15:0] bd,
                       output logic ga, output logic gb,
                       output logic [2:0] owe, output logic [10:0] oaddr);
        logic ega, egb, w, mapped;
        int f;
        logic [15:0] d;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #1;
        ega = ar && (!br || last_b);
        egb = br && (!ar || !last_b);
        chk("a_gnt", a_gnt, ega);
        chk("b_gnt", b_gnt, egb);
        chk("a_rvalid", a_rvalid, pa_rv);
        chk("a_rdata", a_rdata, pa_rd);
        chk("a_err", a_err, pa_err);
        chk("b_rvalid", b_rvalid, pb_rv);
        chk("b_rdata", b_rdata, pb_rd);
        chk("b_err", b_err, pb_err);
        f = egb ? int'(ba) : int'(aa);
        w = egb ? bw : aw;
        d = egb ? bd : ad;
        mapped = (f < 3584);
        chk("bank_we", bank_we, ((ega || egb) && w && mapped) ? exp_oh(f) : 3'b000);
        if ((ega || egb) && mapped) chk("bank_addr", bank_addr, exp_local(f));
        if ((ega || egb) && mapped && w) chk("bank_d", bank_d, d);
        ga = a_gnt; gb = b_gnt; owe = bank_we; oaddr = bank_addr;
        pa_rv = 0; pa_err = 0; pa_rd = '0;
        pb_rv = 0; pb_err = 0; pb_rd = '0;
        if (ega) begin
            pa_rv = !aw; pa_err = !mapped;
            pa_rd = (!aw && mapped) ? ref_mem[f] : 16'h0;
            last_b = 1'b0;
        end
        if (egb) begin
            pb_rv = !bw; pb_err = !mapped;
            pb_rd = (!bw && mapped) ? ref_mem[f] : 16'h0;
            last_b = 1'b1;
        end
        if ((ega || egb) && w && mapped) ref_mem[f] = d;
        @(posedge clk); #1;
    endtask

    task automatic idle_cyc();
        logic ga, gb;
        logic [2:0] owe;
        logic [10:0] oaddr;
        cyc(0, 0, 13'd0, 16'h0, 0, 0, 13'd0, 16'h0, ga, gb, owe, oaddr);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
        a_addr = 13'd10; b_addr = 13'd20;
        #1;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_bank_we", bank_we, 0);
        @(posedge clk); #1;
        chk("rst_busy", fill_busy, 0);
        chk("rst_done", fill_done, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_b_err", b_err, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        reset = 1'b1;
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        clear_model();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ga, gb, ar, aw, br, bw;
        logic [2:0]  owe;
        logic [10:0] oaddr;
        logic [12:0] aa, ba;
        logic [15:0] ad, bd;
        int n_bad, n_done, w0, w1, w2;
        int bnd_addr [5];
        logic [2:0]  bnd_oh [5];
        logic [10:0] bnd_loc [5];

        reset = 1'b0; fill_start = 1'b0; fill_pattern = '0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        clear_model();
        @(posedge clk); #1;
        do_reset();

        // Fill aborted by reset at counter 100.
        fill_pattern = 16'hA5A5; fill_start = 1'b1;
        @(posedge clk); #1;
        fill_start = 1'b0;
        for (int k = 0; k < 100; k++) begin @(posedge clk); #1; end
        chk("abort_addr", bank_addr, 100);
        chk("abort_we_pre", bank_we, 3'b001);
        reset = 1'b0;
        #1;
        chk("abort_we_forced", bank_we, 0);
        @(posedge clk); #1;
        chk("abort_busy", fill_busy, 0);
        chk("abort_we", bank_we, 0);
        reset = 1'b1;
        clear_model();
        n_done = 0; n_bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (fill_done) n_done++;
            if (fill_busy) n_bad++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_no_busy", n_bad, 0);

        // Full fill; a read request is granted in the start cycle, the next is held.
        fill_pattern = 16'hFFFF; fill_start = 1'b1;
        a_req = 1; a_we = 0; a_addr = 13'd5; b_req = 0;
        #1;
        chk("fs_a_gnt", a_gnt, 1);
        chk("fs_busy", fill_busy, 0);
        @(posedge clk); #1;
        fill_start = 1'b0; fill_pattern = 16'h0000; a_addr = 13'd7;
        n_bad = 0; n_done = 0; w0 = 0; w1 = 0; w2 = 0;
        for (int k = 0; k < 3584; k++) begin
            if (k == 0) begin
                chk("fs_rvalid", a_rvalid, 1);
                chk("fs_rdata", a_rdata, 16'hA5A5);
            end
            if (bank_we !== exp_oh(k) || bank_addr !== exp_local(k) || bank_d !== 16'hFFFF
                || a_gnt !== 1'b0 || fill_busy !== 1'b1) n_bad++;
            if (bank_we === 3'b001) w0++;
            if (bank_we === 3'b010) w1++;
            if (bank_we === 3'b100) w2++;
            if (fill_done) n_done++;
            fill_start = (k == 1000);
            @(posedge clk); #1;
        end
        fill_start = 1'b0;
        chk("fill_bad_cycles", n_bad, 0);
        chk("fill_b0_writes", w0, 2048);
        chk("fill_b1_writes", w1, 1024);
        chk("fill_b2_writes", w2, 512);
        chk("fill_done_early", n_done, 0);
        chk("done_pulse", fill_done, 1);
        chk("done_busy", fill_busy, 1);
        chk("done_a_gnt", a_gnt, 0);
        chk("done_we", bank_we, 0);
        @(posedge clk); #1;
        chk("post_done", fill_done, 0);
        chk("post_busy", fill_busy, 0);
        chk("post_a_gnt", a_gnt, 1);
        for (int i = 0; i < 3584; i++) ref_mem[i] = 16'hFFFF;
        last_b = 1'b0;
        pa_rv = 1; pa_rd = 16'hFFFF; pa_err = 0;
        pb_rv = 0; pb_rd = '0; pb_err = 0;
        @(posedge clk); #1;
        idle_cyc();

        // Both requesters held after reset: A,B,A,B,A,B.
        do_reset();
        ar = 1; br = 1; aa = 13'($urandom_range(0, 3583)); ba = 13'($urandom_range(0, 3583));
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, aa, 16'h0, 1, 0, ba, 16'h0, ga, gb, owe, oaddr);
            chk("alt_a", ga, (i % 2) == 0);
            chk("alt_b", gb, (i % 2) == 1);
            if (ga) aa = 13'($urandom_range(0, 3583));
            if (gb) ba = 13'($urandom_range(0, 3583));
        end
        idle_cyc();

        // Bank boundaries.
        bnd_addr = '{2047, 2048, 3071, 3072, 3583};
        bnd_oh   = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
        bnd_loc  = '{11'd2047, 11'd0, 11'd1023, 11'd0, 11'd511};
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 13'(bnd_addr[i]), 16'($urandom), 0, 0, 13'd0, 16'h0, ga, gb, owe, oaddr);
            chk("bnd_we", owe, bnd_oh[i]);
            chk("bnd_local", oaddr, bnd_loc[i]);
        end
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 13'd0, 16'h0, 1, 0, 13'(bnd_addr[i]), 16'h0, ga, gb, owe, oaddr);
        idle_cyc();

        // A writes 0x1234 to 2050 then reads it back.
        cyc(1, 1, 13'd2050, 16'h1234, 0, 0, 13'd0, 16'h0, ga, gb, owe, oaddr);
        chk("w2050_we", owe, 3'b010);
        chk("w2050_addr", oaddr, 2);
        cyc(1, 0, 13'd2050, 16'h0, 0, 0, 13'd0, 16'h0, ga, gb, owe, oaddr);
        chk("r2050_we", owe, 3'b000);
        chk("r2050_exp", pa_rd, 16'h1234);
        idle_cyc();

        // Unmapped accesses from B.
        cyc(0, 0, 13'd0, 16'h0, 1, 0, 13'd3584, 16'h0, ga, gb, owe, oaddr);
        chk("um_rd_we", owe, 0);
        cyc(0, 0, 13'd0, 16'h0, 1, 0, 13'd8191, 16'h0, ga, gb, owe, oaddr);
        cyc(0, 0, 13'd0, 16'h0, 1, 1, 13'd3584, 16'hBEEF, ga, gb, owe, oaddr);
        chk("um_wr_we", owe, 0);
        idle_cyc();

        // Randomized traffic, requests held until granted.
        ar = 0; br = 0; ga = 0; gb = 0; aw = 0; bw = 0; aa = '0; ba = '0; ad = '0; bd = '0;
        for (int i = 0; i < 500; i++) begin
            if (!ar || ga) begin
                ar = ($urandom_range(0, 9) < 6); aw = 1'($urandom_range(0, 1));
                aa = 13'($urandom_range(0, 4095)); ad = 16'($urandom);
            end
            if (!br || gb) begin
                br = ($urandom_range(0, 9) < 6); bw = 1'($urandom_range(0, 1));
                ba = 13'($urandom_range(0, 4095)); bd = 16'($urandom);
            end
            cyc(ar, aw, aa, ad, br, bw, ba, bd, ga, gb, owe, oaddr);
        end
        idle_cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
